hpdcache_mem_responder: RTL and testbench
=========================================

Name: hpdcache_mem_responder

Overview:
Synthesizable memory-side responder for the HPDcache memory interface. It accepts read requests, write requests and write-data beats from the cache. It returns read-response beats and write acknowledgements from an internal two-port RAM. Used as the memory endpoint in FPGA and simulation tops, replacing an AXI adapter plus external memory.

Parameters:
MEM_ADDR_W, 56, byte address width of mem requests
MEM_ID_W, 6, transaction ID width
MEM_DATA_W, 512, beat width in bits; power of 2, >=64
RAM_WORDS, 1024, backing RAM depth in beats; power of 2
BASE_ADDR, 0, byte address mapped to RAM word 0

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
req_read_valid_i  in  1  read request valid
req_read_ready_o  out  1  read request accepted
req_read_addr_i  in  MEM_ADDR_W  start byte address
req_read_len_i  in  8  beats minus one
req_read_id_i  in  MEM_ID_W  transaction ID
resp_read_valid_o  out  1  read beat valid
resp_read_ready_i  in  1  cache accepts beat
resp_read_data_o  out  MEM_DATA_W  beat data
resp_read_id_o  out  MEM_ID_W  echoed ID
resp_read_last_o  out  1  final beat
resp_read_error_o  out  1  out-of-range beat
req_write_valid_i  in  1  write request valid
req_write_ready_o  out  1  write request accepted
req_write_addr_i  in  MEM_ADDR_W  start byte address
req_write_len_i  in  8  beats minus one
req_write_id_i  in  MEM_ID_W  transaction ID
req_write_atomic_i  in  1  atomic command (unsupported)
wdata_valid_i  in  1  write beat valid
wdata_ready_o  out  1  write beat accepted
wdata_i  in  MEM_DATA_W  beat data
wdata_be_i  in  MEM_DATA_W/8  byte enables
wdata_last_i  in  1  final write beat
resp_write_valid_o  out  1  write ack valid
resp_write_ready_i  in  1  cache accepts ack
resp_write_id_o  out  MEM_ID_W  echoed ID
resp_write_error_o  out  1  error (range or atomic)

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - All valid outputs 0; data, ID, last and error outputs 0.
  - req_read_ready_o=1, req_write_ready_o=1, wdata_ready_o=0.
  - RAM contents are not reset.
- Handshakes: a transfer occurs on valid&&ready. Valids never depend combinationally on the corresponding ready. Payload is held stable while valid&&!ready.
- Word index: (addr-BASE_ADDR)>>log2(MEM_DATA_W/8). Low address bits are ignored. A beat is in range iff the index is < RAM_WORDS.
- Read FSM (RD_IDLE, RD_FETCH, RD_SEND):
  - RD_IDLE: ready=1. Request accepted -> latch addr/len/id, go to RD_FETCH.
  - RD_FETCH: issue RAM read (1-cycle latency) -> RD_SEND.
  - RD_SEND: valid=1. On handshake: if last, go to RD_IDLE; else increment index and go to RD_FETCH.
  - First beat is valid 2 cycles after request acceptance. Throughput is 1 beat per 2 cycles; this is acceptable.
  - last is set when the beat counter equals len.
  - Out-of-range beat: data=0, error=1.
  - One outstanding read at a time.
- Write FSM (WR_IDLE, WR_DATA, WR_RESP):
  - WR_IDLE: req_write_ready_o=1. Request accepted -> latch fields, go to WR_DATA.
  - WR_DATA: wdata_ready_o=1. Each accepted beat writes the RAM under byte enables, unless out of range or atomic, in which case it is discarded and a sticky error is set.
  - Exit WR_DATA after accepting the beat with wdata_last_i=1, or after len+1 beats, whichever comes first. A mismatch between the two also sets error.
  - WR_RESP: valid=1 with latched ID and sticky error. On handshake -> WR_IDLE; sticky error is cleared.
  - Write-data beats arriving before the request are held off (wdata_ready_o=0 outside WR_DATA).
- Concurrency: the read and write FSMs run independently. A same-cycle RAM read and write to the same word returns the old data (read-first).
- Reset mid-burst: both FSMs return to IDLE immediately. Partial write bursts remain in RAM. No response is emitted for aborted transactions.
- Address increment wraps modulo 2^MEM_ADDR_W; the range check is applied per beat.

Optional Feature:
HPDCACHE_MEM_RSP_LATENCY_EN
- Defined:
  - Adds an input port lat_cfg_i [7:0].
  - Adds state RD_WAIT between RD_IDLE and RD_FETCH. It counts lat_cfg_i cycles after acceptance, sampling lat_cfg_i at acceptance.
  - The write ack is likewise delayed by lat_cfg_i cycles in WR_RESP before valid rises.
  - lat_cfg_i=0 gives identical timing to the undefined case.
- Undefined: no port, no delay states.

Decomposition:
- Shared package hpdcache_mem_responder_pkg holds:
  - the read and write FSM state enums;
  - the beat-length type (logic [7:0]);
  - a localparam function computing the byte-offset shift from MEM_DATA_W.
- One sub-module, hpdcache_mem_responder_ram: two-port (1R1W), read-first, byte-enable RAM of RAM_WORDS x MEM_DATA_W with 1-cycle read latency.

Test Plan:
- Write then read, single beat: write addr 0x40, id 3, len 0, data 0xA5 repeated, be all ones -> ack id 3, error 0. Read addr 0x40, id 5 -> one beat of 0xA5 pattern, last=1, id 5, error 0.
- Burst with backpressure: read len 3 from 0x0 with resp_read_ready_i toggling every cycle -> 4 beats, words 0..3 in order, last only on beat 4, payload stable while stalled.
- Partial byte enables: write be=0x1 with data 0xFF to a word previously holding 0x00 -> readback low byte 0xFF, all other bytes 0x00.
- Errors:
  - Read at index RAM_WORDS -> data 0, error 1.
  - Atomic write -> RAM unchanged, ack error 1.
  - len=1 with wdata_last_i on beat 1 -> error 1.
- Concurrency: same-cycle read and write of the same word -> read returns the old value; the subsequent read returns the new value. Both IDs are echoed correctly.
- Reset mid-burst: assert rst_i during beat 2 of a 4-beat read -> next cycle resp_read_valid_o=0 and req_read_ready_o=1; a new read completes normally.

Source files
------------

// File: rtl/hpdcache_mem_responder_pkg.sv
// Shared types for the HPDcache memory responder: FSM states, beat length, beat shift.
package hpdcache_mem_responder_pkg;

    // RD_WAIT is only reachable when HPDCACHE_MEM_RSP_LATENCY_EN is defined
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_SEND, RD_WAIT} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

    typedef logic [7:0] beat_len_t;

    // log2 of the number of bytes in one beat: byte address -> word index shift
    function automatic int unsigned beat_shift(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/hpdcache_mem_responder_ram.sv
// 1R1W byte-enable RAM, 1-cycle read latency, read-first on same-word collision.
module hpdcache_mem_responder_ram #(
    parameter int unsigned WORDS  = 1024,
    parameter int unsigned DATA_W = 512,
    localparam int unsigned AW    = $clog2(WORDS)
) (
    input  logic                i_clk,
    input  logic                i_rd_en,
    input  logic [AW-1:0]       i_rd_idx,
    output logic [DATA_W-1:0]   o_rd_data,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_idx,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic [DATA_W/8-1:0] i_wr_be
);

    logic [DATA_W-1:0] r_mem [WORDS];

    // Registered read sees the pre-write contents because both use NBAs on the same edge
    always_ff @(posedge i_clk) begin
        if (i_rd_en)
            o_rd_data <= r_mem[i_rd_idx];
        if (i_wr_en)
            for (int b = 0; b < DATA_W / 8; b++)
                if (i_wr_be[b])
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
    end

endmodule

// File: rtl/hpdcache_mem_responder.sv
// HPDcache memory-side responder backed by an internal RAM.
// Optional: HPDCACHE_MEM_RSP_LATENCY_EN adds lat_cfg_i and delays read data / write acks.
module hpdcache_mem_responder
    import hpdcache_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 56,
    parameter int unsigned MEM_ID_W   = 6,
    parameter int unsigned MEM_DATA_W = 512,
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
    input  logic [7:0]              lat_cfg_i,
`endif
    input  logic                    req_read_valid_i,
    output logic                    req_read_ready_o,
    input  logic [MEM_ADDR_W-1:0]   req_read_addr_i,
    input  logic [7:0]              req_read_len_i,
    input  logic [MEM_ID_W-1:0]     req_read_id_i,
    output logic                    resp_read_valid_o,
    input  logic                    resp_read_ready_i,
    output logic [MEM_DATA_W-1:0]   resp_read_data_o,
    output logic [MEM_ID_W-1:0]     resp_read_id_o,
    output logic                    resp_read_last_o,
    output logic                    resp_read_error_o,
    input  logic                    req_write_valid_i,
    output logic                    req_write_ready_o,
    input  logic [MEM_ADDR_W-1:0]   req_write_addr_i,
    input  logic [7:0]              req_write_len_i,
    input  logic [MEM_ID_W-1:0]     req_write_id_i,
    input  logic                    req_write_atomic_i,
    input  logic                    wdata_valid_i,
    output logic                    wdata_ready_o,
    input  logic [MEM_DATA_W-1:0]   wdata_i,
    input  logic [MEM_DATA_W/8-1:0] wdata_be_i,
    input  logic                    wdata_last_i,
    output logic                    resp_write_valid_o,
    input  logic                    resp_write_ready_i,
    output logic [MEM_ID_W-1:0]     resp_write_id_o,
    output logic                    resp_write_error_o
);

    localparam int unsigned SHIFT = beat_shift(MEM_DATA_W);
    localparam int unsigned IDX_W = $clog2(RAM_WORDS);
    localparam logic [MEM_ADDR_W-1:0] WORDS_A = MEM_ADDR_W'(RAM_WORDS);
    localparam logic [MEM_ADDR_W-1:0] STEP    = MEM_ADDR_W'(MEM_DATA_W / 8);

    rd_state_e r_rd_state, w_rd_next;
    wr_state_e r_wr_state, w_wr_next;

    logic [MEM_ADDR_W-1:0] r_rd_addr, r_wr_addr;
    beat_len_t             r_rd_len, r_rd_cnt, r_wr_len, r_wr_cnt;
    logic [MEM_ID_W-1:0]   r_rd_id, r_wr_id;
    logic                  r_wr_atomic, r_wr_err;
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
    logic [7:0]            r_rd_lat, r_wr_lat;
`endif

    logic [MEM_ADDR_W-1:0] w_rd_word, w_wr_word;
    logic                  w_rd_inrange, w_wr_inrange, w_rd_last, w_wr_cnt_done;
    logic                  w_wbeat, w_wbeat_err, w_wr_en;
    logic [MEM_DATA_W-1:0] w_ram_rdata;

    // Per-beat index and range check; an address below BASE_ADDR wraps high and fails the check
    assign w_rd_word     = (r_rd_addr - BASE_ADDR) >> SHIFT;
    assign w_wr_word     = (r_wr_addr - BASE_ADDR) >> SHIFT;
    assign w_rd_inrange  = w_rd_word < WORDS_A;
    assign w_wr_inrange  = w_wr_word < WORDS_A;
    assign w_rd_last     = r_rd_cnt == r_rd_len;
    assign w_wr_cnt_done = r_wr_cnt == r_wr_len;

    assign w_wbeat     = wdata_valid_i && wdata_ready_o;
    assign w_wbeat_err = !w_wr_inrange || r_wr_atomic || (wdata_last_i != w_wr_cnt_done);
    assign w_wr_en     = w_wbeat && w_wr_inrange && !r_wr_atomic;

    hpdcache_mem_responder_ram #(.WORDS(RAM_WORDS), .DATA_W(MEM_DATA_W)) u_ram (
        .i_clk     (clk_i),
        .i_rd_en   (r_rd_state == RD_FETCH),
        .i_rd_idx  (w_rd_word[IDX_W-1:0]),
        .o_rd_data (w_ram_rdata),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_word[IDX_W-1:0]),
        .i_wr_data (wdata_i),
        .i_wr_be   (wdata_be_i)
    );

    // Response payloads are forced to zero whenever their valid is low
    assign resp_read_data_o   = (resp_read_valid_o && w_rd_inrange) ? w_ram_rdata : '0;
    assign resp_read_error_o  = resp_read_valid_o && !w_rd_inrange;
    assign resp_read_last_o   = resp_read_valid_o && w_rd_last;
    assign resp_read_id_o     = resp_read_valid_o ? r_rd_id : '0;
    assign resp_write_id_o    = resp_write_valid_o ? r_wr_id : '0;
    assign resp_write_error_o = resp_write_valid_o && r_wr_err;

    // FSM state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_state <= RD_IDLE;
            r_wr_state <= WR_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
            r_wr_state <= w_wr_next;
        end
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        w_rd_next         = r_rd_state;
        req_read_ready_o  = 1'b0;
        resp_read_valid_o = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                req_read_ready_o = 1'b1;
                if (req_read_valid_i) begin
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
                    w_rd_next = (lat_cfg_i != 8'd0) ? RD_WAIT : RD_FETCH;
`else
                    w_rd_next = RD_FETCH;
`endif
                end
            end
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
            RD_WAIT:  if (r_rd_lat <= 8'd1) w_rd_next = RD_FETCH;
`endif
            RD_FETCH: w_rd_next = RD_SEND;
            RD_SEND: begin
                resp_read_valid_o = 1'b1;
                if (resp_read_ready_i) w_rd_next = w_rd_last ? RD_IDLE : RD_FETCH;
            end
            default:  w_rd_next = RD_IDLE;
        endcase
    end

    // Write FSM next state and handshake outputs
    always_comb begin
        w_wr_next          = r_wr_state;
        req_write_ready_o  = 1'b0;
        wdata_ready_o      = 1'b0;
        resp_write_valid_o = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                req_write_ready_o = 1'b1;
                if (req_write_valid_i) w_wr_next = WR_DATA;
            end
            WR_DATA: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i && (wdata_last_i || w_wr_cnt_done)) w_wr_next = WR_RESP;
            end
            WR_RESP: begin
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
                resp_write_valid_o = (r_wr_lat == 8'd0);
`else
                resp_write_valid_o = 1'b1;
`endif
                if (resp_write_valid_o && resp_write_ready_i) w_wr_next = WR_IDLE;
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    // Read burst bookkeeping: latch on accept, advance address/count per delivered beat
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_addr <= '0;
            r_rd_len  <= '0;
            r_rd_cnt  <= '0;
            r_rd_id   <= '0;
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
            r_rd_lat  <= '0;
`endif
        end else if (req_read_valid_i && req_read_ready_o) begin
            r_rd_addr <= req_read_addr_i;
            r_rd_len  <= req_read_len_i;
            r_rd_cnt  <= '0;
            r_rd_id   <= req_read_id_i;
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
            r_rd_lat  <= lat_cfg_i;
`endif
        end else if (resp_read_valid_o && resp_read_ready_i) begin
            r_rd_addr <= r_rd_addr + STEP;
            r_rd_cnt  <= r_rd_cnt + 8'd1;
        end
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
        else if (r_rd_state == RD_WAIT) begin
            r_rd_lat <= r_rd_lat - 8'd1;
        end
`endif
    end

    // Write burst bookkeeping and sticky error (cleared once the ack is taken)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_addr   <= '0;
            r_wr_len    <= '0;
            r_wr_cnt    <= '0;
            r_wr_id     <= '0;
            r_wr_atomic <= 1'b0;
            r_wr_err    <= 1'b0;
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
            r_wr_lat    <= '0;
`endif
        end else begin
            if (req_write_valid_i && req_write_ready_o) begin
                r_wr_addr   <= req_write_addr_i;
                r_wr_len    <= req_write_len_i;
                r_wr_cnt    <= '0;
                r_wr_id     <= req_write_id_i;
                r_wr_atomic <= req_write_atomic_i;
            end
            if (w_wbeat) begin
                r_wr_addr <= r_wr_addr + STEP;
                r_wr_cnt  <= r_wr_cnt + 8'd1;
                if (w_wbeat_err) r_wr_err <= 1'b1;
            end
            if (resp_write_valid_o && resp_write_ready_i) r_wr_err <= 1'b0;
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
            if (r_wr_state == WR_DATA && w_wr_next == WR_RESP)
                r_wr_lat <= lat_cfg_i;
            else if (r_wr_state == WR_RESP && r_wr_lat != 8'd0)
                r_wr_lat <= r_wr_lat - 8'd1;
`endif
        end
    end

endmodule

// File: tb/tb_hpdcache_mem_responder.sv
// Directed self-checking bench for hpdcache_mem_responder (default parameters).
module tb_hpdcache_mem_responder;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_read_valid_i, req_read_ready_o;
    logic [55:0]  req_read_addr_i;
    logic [7:0]   req_read_len_i;
    logic [5:0]   req_read_id_i;
    logic         resp_read_valid_o, resp_read_ready_i;
    logic [511:0] resp_read_data_o;
    logic [5:0]   resp_read_id_o;
    logic         resp_read_last_o, resp_read_error_o;
    logic         req_write_valid_i, req_write_ready_o;
    logic [55:0]  req_write_addr_i;
    logic [7:0]   req_write_len_i;
    logic [5:0]   req_write_id_i;
    logic         req_write_atomic_i;
    logic         wdata_valid_i, wdata_ready_o;
    logic [511:0] wdata_i;
    logic [63:0]  wdata_be_i;
    logic         wdata_last_i;
    logic         resp_write_valid_o, resp_write_ready_i;
    logic [5:0]   resp_write_id_o;
    logic         resp_write_error_o;

    int n_chk = 0;
    int n_err = 0;
    logic [511:0] e_data [16];
    logic         e_err  [16];

    always #5 clk_i = ~clk_i;

    hpdcache_mem_responder dut (
        .clk_i(clk_i), .rst_i(rst_i),
`ifdef HPDCACHE_MEM_RSP_LATENCY_EN
        .lat_cfg_i(8'd0),
`endif
        .req_read_valid_i(req_read_valid_i), .req_read_ready_o(req_read_ready_o),
        .req_read_addr_i(req_read_addr_i), .req_read_len_i(req_read_len_i),
        .req_read_id_i(req_read_id_i),
        .resp_read_valid_o(resp_read_valid_o), .resp_read_ready_i(resp_read_ready_i),
        .resp_read_data_o(resp_read_data_o), .resp_read_id_o(resp_read_id_o),
        .resp_read_last_o(resp_read_last_o), .resp_read_error_o(resp_read_error_o),
        .req_write_valid_i(req_write_valid_i), .req_write_ready_o(req_write_ready_o),
        .req_write_addr_i(req_write_addr_i), .req_write_len_i(req_write_len_i),
        .req_write_id_i(req_write_id_i), .req_write_atomic_i(req_write_atomic_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i), .wdata_be_i(wdata_be_i), .wdata_last_i(wdata_last_i),
        .resp_write_valid_o(resp_write_valid_o), .resp_write_ready_i(resp_write_ready_i),
        .resp_write_id_o(resp_write_id_o), .resp_write_error_o(resp_write_error_o)
    );

    function automatic logic [511:0] pat(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One write burst of nb beats; beat i carries pat(seed+i), last asserted on beat lastidx
    task automatic wr_txn(input logic [55:0] addr, input logic [5:0] id, input logic [7:0] len,
                          input logic atomic, input int nb, input int lastidx,
                          input logic [7:0] seed, input logic [63:0] be,
                          input logic exp_err, input string tag);
        int t;
        @(negedge clk_i);
        req_write_valid_i = 1'b1; req_write_addr_i = addr; req_write_id_i = id;
        req_write_len_i = len; req_write_atomic_i = atomic;
        t = 0;
        while (!req_write_ready_o && t < 50) begin @(negedge clk_i); t++; end
        if (!req_write_ready_o) chk({tag, "_req_tmo"}, req_write_ready_o, 1);
        @(negedge clk_i);
        req_write_valid_i = 1'b0; req_write_atomic_i = 1'b0;
        for (int i = 0; i < nb; i++) begin
            wdata_valid_i = 1'b1; wdata_i = pat(seed + 8'(i)); wdata_be_i = be;
            wdata_last_i = (i == lastidx);
            t = 0;
            while (!wdata_ready_o && t < 50) begin @(negedge clk_i); t++; end
            if (!wdata_ready_o) chk({tag, "_wdata_tmo"}, wdata_ready_o, 1);
            @(negedge clk_i);
        end
        wdata_valid_i = 1'b0; wdata_last_i = 1'b0;
        t = 0;
        while (!resp_write_valid_o && t < 50) begin @(negedge clk_i); t++; end
        chk({tag, "_ack_valid"}, resp_write_valid_o, 1);
        chk({tag, "_ack_id"}, resp_write_id_o, id);
        chk({tag, "_ack_err"}, resp_write_error_o, exp_err);
        resp_write_ready_i = 1'b1;
        @(negedge clk_i);
        resp_write_ready_i = 1'b0;
    endtask

    // One read burst checked against e_data/e_err on every valid cycle (also while stalled)
    task automatic rd_txn(input logic [55:0] addr, input logic [5:0] id, input logic [7:0] len,
                          input bit tog, input string tag);
        int t, beat, lat;
        bit seen;
        @(negedge clk_i);
        req_read_valid_i = 1'b1; req_read_addr_i = addr; req_read_id_i = id; req_read_len_i = len;
        resp_read_ready_i = 1'b0;
        t = 0;
        while (!req_read_ready_o && t < 50) begin @(negedge clk_i); t++; end
        if (!req_read_ready_o) chk({tag, "_req_tmo"}, req_read_ready_o, 1);
        @(negedge clk_i);
        req_read_valid_i = 1'b0;
        beat = 0; t = 0; lat = 1; seen = 1'b0;
        while (beat <= int'(len) && t < 200) begin
            resp_read_ready_i = tog ? t[0] : 1'b1;
            if (resp_read_valid_o) begin
                if (!seen) begin chk({tag, "_first_lat"}, lat, 2); seen = 1'b1; end
                chk({tag, "_data"}, resp_read_data_o, e_data[beat]);
                chk({tag, "_id"}, resp_read_id_o, id);
                chk({tag, "_last"}, resp_read_last_o, beat == int'(len));
                chk({tag, "_err"}, resp_read_error_o, e_err[beat]);
                if (resp_read_ready_i) beat++;
            end
            @(negedge clk_i);
            t++; lat++;
        end
        resp_read_ready_i = 1'b0;
        chk({tag, "_beats"}, beat, int'(len) + 1);
        chk({tag, "_idle"}, resp_read_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, hs;
        rst_i = 1'b1;
        req_read_valid_i = 0; req_read_addr_i = '0; req_read_len_i = '0; req_read_id_i = '0;
        resp_read_ready_i = 0;
        req_write_valid_i = 0; req_write_addr_i = '0; req_write_len_i = '0; req_write_id_i = '0;
        req_write_atomic_i = 0; wdata_valid_i = 0; wdata_i = '0; wdata_be_i = '0; wdata_last_i = 0;
        resp_write_ready_i = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_rd_ready", req_read_ready_o, 1);
        chk("rst_wr_ready", req_write_ready_o, 1);
        chk("rst_wdata_ready", wdata_ready_o, 0);
        chk("rst_rd_valid", resp_read_valid_o, 0);
        chk("rst_wr_valid", resp_write_valid_o, 0);
        chk("rst_rd_data", resp_read_data_o, 0);
        chk("rst_rd_last_err", {resp_read_last_o, resp_read_error_o, resp_write_error_o}, 0);
        rst_i = 1'b0;

        // single-beat write then readback (word 1)
        wr_txn(56'h40, 6'd3, 8'd0, 1'b0, 1, 0, 8'hA5, '1, 1'b0, "wr1");
        e_data[0] = pat(8'hA5); e_err[0] = 1'b0;
        rd_txn(56'h40, 6'd5, 8'd0, 1'b0, "rd1");

        // words 0..3 = 0x10..0x13, then a 4-beat read with toggling ready
        wr_txn(56'h0, 6'd9, 8'd3, 1'b0, 4, 3, 8'h10, '1, 1'b0, "wrburst");
        for (int i = 0; i < 4; i++) begin e_data[i] = pat(8'h10 + 8'(i)); e_err[i] = 1'b0; end
        rd_txn(56'h0, 6'd1, 8'd3, 1'b1, "rdburst");

        // partial byte enable on word 5
        wr_txn(56'h140, 6'd2, 8'd0, 1'b0, 1, 0, 8'h00, '1, 1'b0, "wrzero");
        wr_txn(56'h140, 6'd4, 8'd0, 1'b0, 1, 0, 8'hFF, 64'h1, 1'b0, "wrbe");
        e_data[0] = 512'hFF; e_err[0] = 1'b0;
        rd_txn(56'h140, 6'd6, 8'd0, 1'b0, "rdbe");

        // out-of-range read, and a burst crossing the top of RAM
        e_data[0] = '0; e_err[0] = 1'b1;
        rd_txn(56'h10000, 6'd7, 8'd0, 1'b0, "rdoor");
        wr_txn(56'hFFC0, 6'd8, 8'd0, 1'b0, 1, 0, 8'h3C, '1, 1'b0, "wrtop");
        e_data[0] = pat(8'h3C); e_err[0] = 1'b0;
        e_data[1] = '0;         e_err[1] = 1'b1;
        rd_txn(56'hFFC0, 6'd10, 8'd1, 1'b0, "rdcross");

        // write errors: atomic (word 2 must stay 0x12), out of range, early last, missing last
        wr_txn(56'h80, 6'd11, 8'd0, 1'b1, 1, 0, 8'h77, '1, 1'b1, "wratomic");
        e_data[0] = pat(8'h12); e_err[0] = 1'b0;
        rd_txn(56'h80, 6'd14, 8'd0, 1'b0, "rdatomic");
        wr_txn(56'h10000, 6'd15, 8'd0, 1'b0, 1, 0, 8'h55, '1, 1'b1, "wroor");
        wr_txn(56'h180, 6'd16, 8'd1, 1'b0, 1, 0, 8'h66, '1, 1'b1, "wrearly");
        wr_txn(56'h1C0, 6'd17, 8'd0, 1'b0, 1, 5, 8'h67, '1, 1'b1, "wrnolast");
        wr_txn(56'h1C0, 6'd18, 8'd0, 1'b0, 1, 0, 8'h68, '1, 1'b0, "wrclean");

        // same-cycle read and write of word 3: read-first
        @(negedge clk_i);
        req_read_valid_i = 1; req_read_addr_i = 56'hC0; req_read_id_i = 6'd12; req_read_len_i = 0;
        req_write_valid_i = 1; req_write_addr_i = 56'hC0; req_write_id_i = 6'd13;
        req_write_len_i = 0; req_write_atomic_i = 0;
        wdata_valid_i = 1; wdata_i = pat(8'hC3); wdata_be_i = '1; wdata_last_i = 1;
        @(negedge clk_i);
        req_read_valid_i = 0; req_write_valid_i = 0;
        chk("cc_wdata_ready", wdata_ready_o, 1);
        @(negedge clk_i);
        wdata_valid_i = 0; wdata_last_i = 0;
        chk("cc_rvalid", resp_read_valid_o, 1);
        chk("cc_rdata_old", resp_read_data_o, pat(8'h13));
        chk("cc_rid", resp_read_id_o, 6'd12);
        chk("cc_wvalid", resp_write_valid_o, 1);
        chk("cc_wid", resp_write_id_o, 6'd13);
        chk("cc_werr", resp_write_error_o, 0);
        resp_read_ready_i = 1; resp_write_ready_i = 1;
        @(negedge clk_i);
        resp_read_ready_i = 0; resp_write_ready_i = 0;
        e_data[0] = pat(8'hC3); e_err[0] = 1'b0;
        rd_txn(56'hC0, 6'd19, 8'd0, 1'b0, "cc_rdnew");

        // reset while beat 2 of a 4-beat read is presented
        @(negedge clk_i);
        req_read_valid_i = 1; req_read_addr_i = 56'h0; req_read_id_i = 6'd20; req_read_len_i = 8'd3;
        @(negedge clk_i);
        req_read_valid_i = 0; resp_read_ready_i = 1;
        hs = 0; t = 0;
        while (t < 50) begin
            if (resp_read_valid_o) begin
                if (hs == 1) break;
                hs++;
            end
            @(negedge clk_i); t++;
        end
        chk("rst_mid_beat2", resp_read_valid_o, 1);
        rst_i = 1; resp_read_ready_i = 0;
        @(negedge clk_i);
        chk("rst_mid_valid", resp_read_valid_o, 0);
        chk("rst_mid_ready", req_read_ready_o, 1);
        rst_i = 0;
        e_data[0] = pat(8'h10); e_data[1] = pat(8'h11);
        e_data[2] = pat(8'h12); e_data[3] = pat(8'hC3);
        for (int i = 0; i < 4; i++) e_err[i] = 1'b0;
        rd_txn(56'h0, 6'd21, 8'd3, 1'b0, "rd_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
